fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Packet-atomic round-robin arbiter that shares the write (push) port of a single synchronous FIFO between `N_REQ` ready/valid requesters. A grant is held from the first beat of a packet until its `last` beat is accepted, so packets never interleave in the FIFO. Every beat is tagged with the source index for downstream demux. The block sits directly in front of the FIFO's `in_valid`/`in_ready`/`in_data` ports.

## Interface
- `N_REQ`, 4: number of requesters; must be ≥2.
- `WIDTH`, 32: data width per beat.
- `SRC_W`, `$clog2(N_REQ)`: source-tag width (derived; do not override).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester beat valid.
- `req_ready`  out  N_REQ  per-requester beat accepted; at most one bit set.
- `req_data`  in  N_REQ×WIDTH  packed beat data; requester i uses bits [i*WIDTH +: WIDTH].
- `req_last`  in  N_REQ  per-requester end-of-packet marker.
- `out_valid`  out  1  beat to FIFO push side.
- `out_ready`  in  1  FIFO `in_ready`.
- `out_data`  out  WIDTH  beat data.
- `out_src`  out  SRC_W  index of the granted requester.
- `out_last`  out  1  end-of-packet for the current beat.
- `busy`  out  1  high while in LOCKED.

## Operation
- FSM states: IDLE, LOCKED.
- IDLE: if any `req_valid` is set, pick the first set bit searching from `rr_ptr` upward, with modulo-N_REQ wrap. Register it into `grant`, then go to LOCKED. If no request is set, stay in IDLE. All `req_ready` are 0 and `out_valid` is 0 in IDLE.
- LOCKED:
  - `out_valid = req_valid[grant]`, `out_data/out_last = req_*[grant]`, `out_src = grant`.
  - `req_ready[grant] = out_ready`; all other `req_ready` bits are 0.
  - A beat transfers when `out_valid && out_ready`.
  - When a transferred beat has `out_last = 1`: go to IDLE and set `rr_ptr <= (grant+1) mod N_REQ`.
  - Otherwise stay in LOCKED.
  - If `req_valid[grant]` drops mid-packet, the grant is held and nothing is released.
- `rr_ptr` changes only on packet completion. The just-served requester becomes lowest priority.
- A single-beat packet (`last` on the first beat) is legal. It completes in one LOCKED cycle when `out_ready = 1`.
- Requests that arrive while LOCKED wait. They are considered at the next IDLE cycle.

## Timing
- Reset values: state = IDLE, `rr_ptr = 0`, `grant = 0`, `req_ready = 0`, `out_valid = 0`, `out_src = 0`, `out_last = 0`, `out_data = 0` (data gated to 0 in IDLE), `busy = 0`.
- Assertion of `rst` forces these values asynchronously, including mid-packet. The partially written packet in the FIFO is the system's responsibility.
- Arbitration latency: request seen in IDLE at cycle t → `grant` registered at edge t+1 → first beat can transfer in cycle t+1.
- There is exactly one IDLE bubble cycle between consecutive packets.
- Throughput inside a packet is one beat per cycle while `out_ready = 1`.
- The datapath from the selected `req_*` to `out_*` is combinational, and so is `out_ready` → `req_ready`. There is no registered stage.
- Backpressure: while `out_ready = 0`, no `req_ready` is asserted and the FSM holds.

## Structure
- Package `fifo_arb_pkg`: `typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e`, plus a function `rr_next(req, ptr)` that returns the winning index.
- Sub-module `rr_pick` (combinational rotate-and-priority-encode, parameterised on N_REQ) is natural. It is reusable elsewhere.
- Top level instantiates `fifo_wr_arbiter` followed by the existing synchronous FIFO.

## Test plan
- Requester 1 only, 3-beat packet (0xA0, 0xA1, 0xA2 with last) and `out_ready = 1`: grant is set 1 cycle after the request. Beats appear on consecutive cycles with `out_src = 1`, then state returns to IDLE and `rr_ptr = 2`.
- Requesters 0 and 2 request simultaneously from reset, 2 beats each: all of packet 0 is sent, one bubble cycle, then all of packet 2 with no interleaving. Final `rr_ptr = 3`.
- All four requesters always valid, 1-beat packets: grant order is 0,1,2,3,0,1. Pointer wraps 3→0 and no requester is skipped.
- Requester 3 with a 4-beat packet, `out_ready` low on beats 2–3 for 2 cycles each: `req_ready[3]` stays low during those cycles, data is held, and no beats are lost or duplicated.
- Requester 0 drops `req_valid` for 3 cycles mid-packet while requester 1 is valid: the grant stays on 0 and requester 1 is granted only after 0's last beat.
- `rst` asserted during beat 2 of a packet: outputs return to reset values in the same cycle without waiting for `clk`. After deassertion the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin winner function for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    // First set bit of req at or above ptr, wrapping modulo n_req.
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   ptr,
        input int                    n_req
    );
        logic [RR_IDX_W-1:0] win;
        logic                found;
        int                  idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            if (k < n_req) begin
                idx = (int'(ptr) + k) % n_req;
                if (!found && req[idx]) begin
                    win   = RR_IDX_W'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority-encode: picks the first requester at or after ptr.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SRC_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic             any,
    output logic [SRC_W-1:0] idx
);

    logic [RR_MAX_REQ-1:0] req_ext;
    logic [RR_IDX_W-1:0]   win;

    assign req_ext = RR_MAX_REQ'(req);
    assign win     = rr_next(req_ext, RR_IDX_W'(ptr), N_REQ);
    assign idx     = SRC_W'(win);
    assign any     = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter in front of a FIFO push port; beats are tagged with source.
//   state      | meaning
//   ARB_IDLE   | no grant; pick next requester from rr_ptr
//   ARB_LOCKED | grant held until the granted packet's last beat is accepted
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int SRC_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SRC_W-1:0]       out_src,
    output logic                   out_last,
    output logic                   busy
);

    arb_state_e       state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             pick_any;
    logic [SRC_W-1:0] pick_idx;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == SRC_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_src   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                busy      = 1'b1;
                out_valid = sel_valid;
                out_data  = sel_data;
                out_last  = sel_last;
                out_src   = grant_q;
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant_q == SRC_W'(i)) req_ready[i] = out_ready;
                end
                // Only a completed packet moves the pointer; served requester drops to lowest priority.
                if (sel_valid && out_ready && sel_last) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (grant_q == SRC_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: packet-level reference model plus directed scenarios with literal expectations.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, req_last;
    logic [N*W-1:0] req_data;
    logic           out_valid, out_ready, out_last, busy;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: who owns the port and where the rotation starts
    bit m_locked, n_locked;
    int m_grant, n_grant, m_ptr, n_ptr;

    // requester-side packet sources
    int         pkts_left[N];
    int         len[N];
    int         beat[N];
    logic [W-1:0] base[N];
    int         vpct[N];
    int         rpct;
    bit         rand_mode;
    bit         acc[N];

    int           log_src[$];
    logic [W-1:0] log_data[$];
    int           log_cyc[$];
    int           cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (pkts_left[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (pkts_left[i] > 0 && $urandom_range(99) < vpct[i]) begin
                req_valid[i]           = 1'b1;
                req_data[i*W +: W]     = base[i] + W'(beat[i]);
                req_last[i]            = (beat[i] == len[i] - 1);
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*W +: W]     = $urandom;
                req_last[i]            = 1'($urandom_range(1));
            end
        end
        out_ready = ($urandom_range(99) < rpct);
    endtask

    task automatic step();
        logic [N-1:0] e_ready;
        logic         e_valid, e_last, e_busy;
        logic [W-1:0] e_data;
        int           e_src;
        @(negedge clk);
        e_ready = '0; e_valid = 1'b0; e_last = 1'b0; e_busy = 1'b0; e_data = '0; e_src = 0;
        if (m_locked) begin
            e_busy           = 1'b1;
            e_valid          = req_valid[m_grant];
            e_data           = req_data[m_grant*W +: W];
            e_last           = req_last[m_grant];
            e_src            = m_grant;
            e_ready[m_grant] = out_ready;
        end
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("out_data",  64'(out_data),  64'(e_data));
        chk("out_src",   64'(out_src),   64'(e_src));
        chk("out_last",  64'(out_last),  64'(e_last));
        chk("busy",      64'(busy),      64'(e_busy));
        n_locked = m_locked; n_grant = m_grant; n_ptr = m_ptr;
        if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!n_locked && req_valid[j]) begin
                    n_locked = 1'b1;
                    n_grant  = j;
                end
            end
        end else if (req_valid[m_grant] && out_ready && req_last[m_grant]) begin
            n_locked = 1'b0;
            n_ptr    = (m_grant + 1) % N;
        end
        if (out_valid === 1'b1 && out_ready) begin
            log_src.push_back(int'(out_src));
            log_data.push_back(out_data);
            log_cyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++) acc[i] = (req_ready[i] === 1'b1) && req_valid[i];
        @(posedge clk);
        #1;
        m_locked = n_locked; m_grant = n_grant; m_ptr = n_ptr;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                beat[i]++;
                if (beat[i] == len[i]) begin
                    beat[i] = 0;
                    pkts_left[i]--;
                    if (rand_mode) begin
                        base[i] = $urandom;
                        len[i]  = $urandom_range(1, 5);
                    end
                end
            end
        end
        drive_inputs();
    endtask

    task automatic run(input int max);
        int k = 0;
        while ((pending() || m_locked) && k < max) begin
            step();
            k++;
        end
        n_checks++;
        if (pending() || m_locked) begin
            n_errors++;
            $display("FAIL timeout: packets still pending after %0d cycles", max);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0;
        m_locked = 1'b0; m_grant = 0; m_ptr = 0;
        rand_mode = 1'b0;
        rpct = 100;
        for (int i = 0; i < N; i++) begin
            pkts_left[i] = 0; beat[i] = 0; len[i] = 1; base[i] = '0; vpct[i] = 100;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_src",   64'(out_src),   64'd0);
        chk("rst busy",      64'(busy),      64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        log_src.delete(); log_data.delete(); log_cyc.delete();
        drive_inputs();
    endtask

    task automatic clear_log();
        log_src.delete(); log_data.delete(); log_cyc.delete();
    endtask

    task automatic chk_xfer(input string nm, input int k, input int e_src, input logic [W-1:0] e_data, input int e_cyc);
        if (k >= log_src.size()) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: transfer %0d missing, got %0d transfers", nm, k, log_src.size());
        end else begin
            chk({nm, " src"}, 64'(log_src[k]), 64'(e_src));
            chk({nm, " data"}, 64'(log_data[k]), 64'(e_data));
            if (e_cyc >= 0) chk({nm, " cycle"}, 64'(log_cyc[k]), 64'(e_cyc));
        end
    endtask

    task automatic add_pkt(input int i, input int n_beats, input logic [W-1:0] b);
        pkts_left[i] = 1; len[i] = n_beats; base[i] = b; beat[i] = 0;
    endtask

    initial begin
        // requester 1 alone, 3 beats, then pointer must sit at 2
        reset_dut();
        add_pkt(1, 3, 32'hA0);
        drive_inputs();
        run(50);
        chk("s1 count", 64'(log_src.size()), 64'd3);
        for (int k = 0; k < 3; k++) chk_xfer("s1 beat", k, 1, 32'hA0 + W'(k), k + 1);
        clear_log();
        add_pkt(1, 1, 32'hB0);
        add_pkt(2, 1, 32'hC0);
        drive_inputs();
        run(50);
        chk_xfer("s1 ptr2 first", 0, 2, 32'hC0, -1);
        chk_xfer("s1 ptr2 second", 1, 1, 32'hB0, -1);

        // requesters 0 and 2 together, one bubble between packets, pointer ends at 3
        reset_dut();
        add_pkt(0, 2, 32'h10);
        add_pkt(2, 2, 32'h20);
        drive_inputs();
        run(50);
        chk_xfer("s2 p0b0", 0, 0, 32'h10, 1);
        chk_xfer("s2 p0b1", 1, 0, 32'h11, 2);
        chk_xfer("s2 p2b0", 2, 2, 32'h20, 4);
        chk_xfer("s2 p2b1", 3, 2, 32'h21, 5);
        clear_log();
        add_pkt(0, 1, 32'h30);
        add_pkt(3, 1, 32'h33);
        drive_inputs();
        run(50);
        chk_xfer("s2 ptr3", 0, 3, 32'h33, -1);

        // all four always valid with single-beat packets: strict rotation with wrap
        reset_dut();
        for (int i = 0; i < N; i++) begin
            add_pkt(i, 1, 32'h40 + W'(i));
            pkts_left[i] = 2;
        end
        drive_inputs();
        run(100);
        begin
            int exp_order[6] = '{0, 1, 2, 3, 0, 1};
            for (int k = 0; k < 6; k++)
                chk_xfer("s3 order", k, exp_order[k], 32'h40 + W'(exp_order[k]), 2 * k + 1);
        end

        // requester 3, 4 beats under random backpressure: nothing lost or duplicated
        reset_dut();
        add_pkt(3, 4, 32'hD0);
        rpct = 40;
        drive_inputs();
        run(200);
        chk("s4 count", 64'(log_src.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk_xfer("s4 beat", k, 3, 32'hD0 + W'(k), -1);

        // requester 0 stalls mid-packet while 1 waits: 0 keeps the grant to the end
        reset_dut();
        add_pkt(0, 4, 32'hE0);
        add_pkt(1, 2, 32'hF0);
        vpct[0] = 35;
        drive_inputs();
        req_valid[0] = 1'b1; req_data[0 +: W] = 32'hE0; req_last[0] = 1'b0;
        run(300);
        for (int k = 0; k < 4; k++) chk_xfer("s5 owner", k, 0, 32'hE0 + W'(k), -1);
        chk_xfer("s5 next0", 4, 1, 32'hF0, -1);
        chk_xfer("s5 next1", 5, 1, 32'hF1, -1);

        // asynchronous reset during beat 2, checked before the next clock edge
        reset_dut();
        add_pkt(1, 4, 32'h60);
        drive_inputs();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst out_valid", 64'(out_valid), 64'd0);
        chk("arst req_ready", 64'(req_ready), 64'd0);
        chk("arst busy",      64'(busy),      64'd0);
        chk("arst out_data",  64'(out_data),  64'd0);
        chk("arst out_last",  64'(out_last),  64'd0);
        reset_dut();
        add_pkt(1, 1, 32'h71);
        add_pkt(3, 1, 32'h73);
        drive_inputs();
        run(50);
        chk_xfer("arst first grant", 0, 1, 32'h71, 1);

        // randomized traffic against the model
        reset_dut();
        rand_mode = 1'b1;
        rpct = 65;
        for (int i = 0; i < N; i++) begin
            pkts_left[i] = $urandom_range(3, 8);
            len[i]       = $urandom_range(1, 5);
            base[i]      = $urandom;
            vpct[i]      = 75;
        end
        drive_inputs();
        run(5000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
